// File: rtl/hdq_master.sv
// HDQ single-wire host controller: break, command byte, then write data or read data
// with response timeout. Every bus phase is timed from an internal microsecond tick.
module hdq_master #(
    parameter int unsigned TICK_DIV  = 133,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned T_BREAK   = 190,
    parameter int unsigned T_BRK_REC = 40,
    parameter int unsigned T_CYCLE   = 190,
    parameter int unsigned T_HW1     = 40,
    parameter int unsigned T_HW0     = 120,
    parameter int unsigned T_SAMPLE  = 60,
    parameter int unsigned T_TO      = 320
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [6:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    input  logic              dq_in,
    output logic              dq_oe
);

    localparam int unsigned TDW = $clog2(TICK_DIV);
    localparam int unsigned M1  = (T_BREAK > T_BRK_REC) ? T_BREAK : T_BRK_REC;
    localparam int unsigned M2  = (M1 > T_CYCLE) ? M1 : T_CYCLE;
    localparam int unsigned M3  = (M2 > T_TO) ? M2 : T_TO;
    localparam int unsigned M4  = (M3 > T_SAMPLE) ? M3 : T_SAMPLE;
    localparam int unsigned PHW = $clog2(M4 + 1);
    localparam int unsigned BCW = $clog2(DATA_W);
    localparam int unsigned TXW = 8 + DATA_W;

    typedef enum logic [2:0] {
        StIdle,
        StBreak,
        StBrkRec,
        StCmd,
        StWdata,
        StRwait,
        StRbit,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [TDW-1:0]    tdiv_q, tdiv_d;
    logic [PHW-1:0]    ph_q, ph_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [TXW-1:0]    tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rw_q, rw_d;
    logic              to_q, to_d;
    logic              oe_q, oe_d;
    logic              smp_q, smp_d;
    logic [2:0]        sync_q, sync_d;

    logic              tick;
    logic              tick_clr;
    logic              dq_s;
    logic              fall;
    logic [PHW-1:0]    ph_inc;
    logic [PHW-1:0]    low_ticks;

    // sync_q[1] is the synchronised pad level, sync_q[2] its one-cycle-old copy
    assign dq_s      = sync_q[1];
    assign fall      = sync_q[2] & ~sync_q[1];
    assign tick      = (tdiv_q == TDW'(TICK_DIV - 1));
    assign ph_inc    = ph_q + 1'b1;
    assign low_ticks = tx_q[0] ? PHW'(T_HW1) : PHW'(T_HW0);

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign timeout = to_q;
    assign rdata   = rdata_q;
    assign dq_oe   = oe_q;

    // Next-state logic; dq_oe is computed one cycle ahead so the pad drive is a clean flop
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        rw_d     = rw_q;
        to_d     = to_q;
        oe_d     = oe_q;
        smp_d    = smp_q;
        tick_clr = 1'b0;
        sync_d   = {sync_q[1:0], dq_in};

        unique case (state_q)
            StIdle: begin
                oe_d = 1'b0;
                if (start) begin
                    state_d  = StBreak;
                    tx_d     = {wdata, rw, addr};
                    rw_d     = rw;
                    to_d     = 1'b0;
                    ph_d     = '0;
                    bit_d    = '0;
                    tick_clr = 1'b1;
                    oe_d     = 1'b1;
                end
            end
            StBreak: begin
                if (tick) begin
                    if (ph_q == PHW'(T_BREAK - 1)) begin
                        state_d = StBrkRec;
                        ph_d    = '0;
                        oe_d    = 1'b0;
                    end else begin
                        ph_d = ph_inc;
                    end
                end
            end
            StBrkRec: begin
                if (tick) begin
                    if (ph_q == PHW'(T_BRK_REC - 1)) begin
                        state_d = StCmd;
                        ph_d    = '0;
                        oe_d    = 1'b1;
                    end else begin
                        ph_d = ph_inc;
                    end
                end
            end
            StCmd, StWdata: begin
                if (tick) begin
                    if (ph_q == PHW'(T_CYCLE - 1)) begin
                        ph_d  = '0;
                        tx_d  = tx_q >> 1;
                        bit_d = bit_q + 1'b1;
                        oe_d  = 1'b1;
                        if (state_q == StCmd && bit_q == BCW'(7)) begin
                            bit_d = '0;
                            if (rw_q) begin
                                state_d = StWdata;
                            end else begin
                                state_d = StRwait;
                                oe_d    = 1'b0;
                            end
                        end else if (state_q == StWdata && bit_q == BCW'(DATA_W - 1)) begin
                            state_d = StDone;
                            bit_d   = '0;
                            oe_d    = 1'b0;
                        end
                    end else begin
                        ph_d = ph_inc;
                        if (ph_inc == low_ticks) begin
                            oe_d = 1'b0;
                        end
                    end
                end
            end
            StRwait: begin
                oe_d = 1'b0;
                if (fall) begin
                    // Realign the tick to the slave edge so the sample point is exact
                    state_d  = StRbit;
                    ph_d     = '0;
                    smp_d    = 1'b0;
                    tick_clr = 1'b1;
                end else if (tick) begin
                    if (ph_q == PHW'(T_TO - 1)) begin
                        to_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        ph_d = ph_inc;
                    end
                end
            end
            StRbit: begin
                if (!smp_q) begin
                    if (tick) begin
                        if (ph_q == PHW'(T_SAMPLE - 1)) begin
                            rx_d  = {dq_s, rx_q[DATA_W-1:1]};
                            smp_d = 1'b1;
                            ph_d  = '0;
                        end else begin
                            ph_d = ph_inc;
                        end
                    end
                end else if (dq_s) begin
                    ph_d     = '0;
                    tick_clr = 1'b1;
                    if (bit_q == BCW'(DATA_W - 1)) begin
                        state_d = StDone;
                        rdata_d = rx_q;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = StRwait;
                    end
                end else if (tick) begin
                    if (ph_q == PHW'(T_TO - 1)) begin
                        to_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        ph_d = ph_inc;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                oe_d    = 1'b0;
            end
            default: begin
                state_d = StIdle;
                oe_d    = 1'b0;
            end
        endcase
    end

    // Tick divider wraps every TICK_DIV cycles; restarted on accept and slave-edge alignment
    assign tdiv_d = (tick || tick_clr) ? '0 : tdiv_q + 1'b1;

    // State registers with synchronous reset; synchroniser resets to the idle-high bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tdiv_q  <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            to_q    <= 1'b0;
            oe_q    <= 1'b0;
            smp_q   <= 1'b0;
            sync_q  <= 3'b111;
        end else begin
            state_q <= state_d;
            tdiv_q  <= tdiv_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            to_q    <= to_d;
            oe_q    <= oe_d;
            smp_q   <= smp_d;
            sync_q  <= sync_d;
        end
    end

endmodule

// File: doc/hdq_master.md
# hdq_master

Parametrised single-wire HDQ host controller, the successor of the fixed 8-bit read-only HDQ interface. Times every bus phase from its own clock-derived microsecond tick; no external reference clock. Supports read and write transactions, 8- or 16-bit data, and a response timeout. Sits between the system register/control logic and an open-drain DQ pad; the pad wrapper is outside this block.

## Interface
- TICK_DIV, 133 — clk cycles per 1 µs tick (≥2)
- DATA_W, 8 — data bits per transaction; only 8 or 16 are legal
- T_BREAK, 190 — break low time, ticks
- T_BRK_REC, 40 — break recovery (released) time, ticks
- T_CYCLE, 190 — host bit cycle length, ticks
- T_HW1, 40 / T_HW0, 120 — host low time for a 1 / a 0, ticks
- T_SAMPLE, 60 — ticks from slave falling edge to read sample
- T_TO, 320 — max ticks to wait for a slave falling edge
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- rw  in  1  1 = write, 0 = read; captured with start
- addr  in  7  register address; captured with start
- wdata  in  DATA_W  write data; captured with start
- rdata  out  DATA_W  last successfully read data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- timeout  out  1  sticky abort flag for the last transaction
- dq_in  in  1  raw DQ pad input (asynchronous)
- dq_oe  out  1  1 = pull DQ low; 0 = release (bus pulled up externally)

## Operation
- dq_in passes through a 2-flop synchroniser; edge detection uses the synchronised signal plus one delay flop.
- Tick generator: counter 0..TICK_DIV-1, tick pulse on wrap. Counter clears when start is accepted, so phases are exact multiples of TICK_DIV cycles.
- Command byte, sent LSB first: bits 6:0 = addr, bit 7 = rw. Data is LSB first.
- States:
  - IDLE: dq_oe=0, busy=0. On start, capture inputs, clear timeout, go to BREAK.
  - BREAK: dq_oe=1 for T_BREAK ticks, then go to BRK_REC.
  - BRK_REC: dq_oe=0 for T_BRK_REC ticks, then go to CMD.
  - CMD: 8 host bit cycles. Each cycle: dq_oe=1 for T_HW1 (bit=1) or T_HW0 (bit=0), then release until T_CYCLE. After the last cycle, go to WDATA if rw=1, else to RWAIT.
  - WDATA: DATA_W host bit cycles of the captured wdata, then DONE.
  - RWAIT: dq_oe=0. A synchronised falling edge goes to RBIT. If T_TO ticks elapse first, set timeout=1 and go to DONE.
  - RBIT: after T_SAMPLE ticks, shift in the synchronised dq_in (high = 1). Then wait for dq_in high. If it is not high within T_TO ticks, set timeout and go to DONE. After DATA_W bits, load rdata from the shift register and go to DONE; otherwise return to RWAIT.
  - DONE: done=1 for one cycle, then IDLE.
- rdata updates only on a complete, non-timed-out read. A write or an aborted read leaves it unchanged.
- start while busy is ignored. start held high re-triggers on the cycle after DONE.
- rst at any point: state=IDLE and dq_oe=0 on the next edge. No done pulse.

## Timing
- Reset values: dq_oe=0, busy=0, done=0, timeout=0, rdata=0.
- busy rises the cycle after start is sampled. dq_oe rises the same cycle.
- Write latency, from start accept to done: (T_BREAK+T_BRK_REC+(8+DATA_W)·T_CYCLE)·TICK_DIV cycles, ±2.
- Read latency depends on the slave. done follows the final sample by ≤2 cycles.
- Phase boundaries land on tick edges. The sampling delay adds 2–3 clk cycles of sync latency.
- Timeout window restarts at entry to RWAIT and at each bit's wait-for-high.

## Test plan
- TICK_DIV=4, DATA_W=8, write addr=0x15 wdata=0xA5 → dq_oe shows a 190-tick break, then bits 1,0,1,0,1,0,0,1 (cmd 0x95) and 1,0,1,0,0,1,0,1 (0xA5) with 40/120-tick lows. done arrives 3270 ticks after start; rdata unchanged; timeout=0.
- Read addr=0x0E, slave model returns 0x3C (low 40 µs for 1, 100 µs for 0, 190 µs cycles) → cmd lows encode 0x0E, then rdata=0x3C, done pulse, timeout=0.
- DATA_W=16 read, slave returns 0xBEEF → rdata=0xBEEF after 16 bits.
- Read with no slave response → timeout=1 and done pulse 320 ticks after the last cmd bit cycle ends; rdata keeps its prior value; next start clears timeout.
- rst asserted mid-BREAK → dq_oe=0 and busy=0 on the next cycle; no done pulse. A new start runs a full transaction.
- start pulses during busy → ignored. Exactly one done pulse per accepted start.
